// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and helpers for the UART transmit path.
// PARITY exists in the encoding even when UART_TX_PARITY_EN is undefined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_states_e;

  function automatic int baud_div(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter, clearable by the owner.
// tick_o marks the last clock of a bit period.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: parallel-in UART frame serialiser with valid/ready acceptance.
// Optional parity bit compiled in by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_div_chk
    $error("uart_tx: BAUD_DIV must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]            state, state_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  par_q;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_d != state),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    unique case (state)
      S_IDLE: begin
        if (valid_i) begin
          state_d   = S_START;
          shreg_d   = data_i;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        shreg_d   = '0;
      end
    endcase
  end

  // Line level is a function of the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (state == S_IDLE && valid_i) begin
      par_q <= (^data_i) ^ PARITY_ODD;
    end
  end
`else
  assign par_q = 1'b1;
`endif

  assign ready_o = (state == S_IDLE);
  assign busy_o  = !ready_o;
  assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx frames against a bit-list model of the line.
// Two instances: one stop bit and two stop bits.
module tb_uart_tx;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int DIV = 10;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  localparam bit PODD = 1'b0;
`else
  localparam int P = 0;
  localparam bit PODD = 1'b0;
`endif
  localparam int FRAME1 = (1 + DW + P + 1) * DIV;
  localparam int FRAME2 = (1 + DW + P + 2) * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] data2 = '0;
  logic valid = 1'b0;
  logic valid2 = 1'b0;
  logic tx, ready, busy;
  logic tx2, ready2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ   (CF),
    .BAUD_RATE  (BR),
    .DATA_WIDTH (DW),
    .STOP_BITS  (1)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data),
    .valid_i (valid),
    .ready_o (ready),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  uart_tx #(
    .CLK_FREQ   (CF),
    .BAUD_RATE  (BR),
    .DATA_WIDTH (DW),
    .STOP_BITS  (2)
  ) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data2),
    .valid_i (valid2),
    .ready_o (ready2),
    .tx_o    (tx2),
    .busy_o  (busy2)
  );

  // Line level k clocks after the acceptance edge, from the frame as a bit list.
  function automatic logic exp_bit(
    input logic [7:0] d,
    input int k,
    input int stops
  );
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (P == 1) q.push_back((^d) ^ PODD);
    for (int s = 0; s < stops; s++) q.push_back(1'b1);
    if (k / DIV < q.size()) return q[k / DIV];
    return 1'b1;
  endfunction

  // Called at a negedge with ready high; returns at the negedge k=0.
  task automatic start_word(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic check_frame(
    input logic [7:0] d,
    input string nm,
    output logic par_bit
  );
    par_bit = 1'bx;
    for (int k = 0; k < FRAME1; k++) begin
      if (k == 9 * DIV + DIV / 2) par_bit = tx;
      checks++;
      if (tx !== exp_bit(d, k, 1)) begin
        errors++;
        $display("FAIL %s tx k=%0d got=%b exp=%b",
                 nm, k, tx, exp_bit(d, k, 1));
      end
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s ready k=%0d got=%b/%b exp=0/1",
                 nm, k, ready, busy);
      end
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s end k=%0d got r=%b b=%b tx=%b exp 1 0 1",
               nm, FRAME1, ready, busy, tx);
    end
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (ready !== 1'b1 && t < 4 * FRAME1) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout got ready=%b exp=1", nm, ready);
    end
  endtask

  task automatic rx_word(output logic [7:0] w, output bit ok);
    int t = 0;
    w  = '0;
    ok = 1'b0;
    while (tx !== 1'b0 && t < 4 * FRAME1) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) return;
    repeat (DIV / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < DW; i++) begin
      repeat (DIV) @(negedge clk);
      w[i] = tx;
    end
    if (P == 1) repeat (DIV) @(negedge clk);
    repeat (DIV) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got tx=%b r=%b b=%b exp 1 1 0",
               tx, ready, busy);
    end
    checks++;
    if (tx2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset2 got tx=%b r=%b b=%b exp 1 1 0",
               tx2, ready2, busy2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic pb;
    start_word(8'hA5);
    check_frame(8'hA5, "basic_a5", pb);
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] w0, w1;
    bit ok0, ok1;
    fork
      begin
        start_word(8'h3C);
        wait_ready("loop_gap");
        start_word(8'hFF);
      end
      begin
        rx_word(w0, ok0);
        rx_word(w1, ok1);
      end
    join
    checks++;
    if (!ok0 || w0 !== 8'h3C) begin
      errors++;
      $display("FAIL loop_w0 got=%h ok=%0d exp=3c", w0, ok0);
    end
    checks++;
    if (!ok1 || w1 !== 8'hFF) begin
      errors++;
      $display("FAIL loop_w1 got=%h ok=%0d exp=ff", w1, ok1);
    end
    wait_ready("loop_end");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic pb;
    data  = 8'h01;
    valid = 1'b1;
    @(negedge clk);
    data = 8'hC3;
    fork
      check_frame(8'h01, "b2b_f1", pb);
      begin
        repeat (50) @(negedge clk);
        data = 8'h80;
      end
    join
    @(negedge clk);
    data  = 8'($urandom);
    valid = 1'b0;
    fork
      check_frame(8'h80, "b2b_f2", pb);
      begin
        repeat (40) @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
      end
    join
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_noqueue got tx=%b r=%b exp 1 1", tx, ready);
    end
  endtask

  task automatic test_reset_mid();
    logic pb;
    start_word(8'h96);
    for (int k = 0; k < 45; k++) begin
      checks++;
      if (tx !== exp_bit(8'h96, k, 1)) begin
        errors++;
        $display("FAIL rstmid tx k=%0d got=%b exp=%b",
                 k, tx, exp_bit(8'h96, k, 1));
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort got tx=%b r=%b b=%b exp 1 1 0",
               tx, ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_word(8'h55);
    check_frame(8'h55, "rstmid_55", pb);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic pb;
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_word(d);
      check_frame(d, $sformatf("rand%0d_%h", n, d), pb);
    end
    @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic pb;
    start_word(8'hA5);
    check_frame(8'hA5, "par_a5", pb);
    checks++;
    if (pb !== 1'b0) begin
      errors++;
      $display("FAIL par_a5_bit got=%b exp=0", pb);
    end
    @(negedge clk);
    start_word(8'h07);
    check_frame(8'h07, "par_07", pb);
    checks++;
    if (pb !== 1'b1) begin
      errors++;
      $display("FAIL par_07_bit got=%b exp=1", pb);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_stop2();
    int lows = 0;
    int rise = -1;
    data2  = 8'h00;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    for (int k = 0; k <= FRAME2 + 2; k++) begin
      if (k < FRAME2) begin
        checks++;
        if (tx2 !== exp_bit(8'h00, k, 2)) begin
          errors++;
          $display("FAIL stop2 tx k=%0d got=%b exp=%b",
                   k, tx2, exp_bit(8'h00, k, 2));
        end
      end
      if (tx2 === 1'b0) lows++;
      if (ready2 === 1'b1 && rise < 0) rise = k;
      @(negedge clk);
    end
    checks++;
    if (lows != (1 + DW + P) * DIV) begin
      errors++;
      $display("FAIL stop2_lows got=%0d exp=%0d",
               lows, (1 + DW + P) * DIV);
    end
    checks++;
    if (rise != FRAME2) begin
      errors++;
      $display("FAIL stop2_ready got=%0d exp=%0d", rise, FRAME2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stop2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
